mul_share_arb: RTL

- Round-robin arbiter and sequencer that shares the team's single sequential 8x8 multiplier between N_REQ requesters.
- Accepts one operand pair at a time and drives the multiplier's level start / a / b inputs. Waits for done, then returns the 16-bit product to the owning requester.
- Includes a watchdog timeout so a hung multiplier cannot lock out the other requesters.
- Sits between requester blocks and the multiplier top.

---
 rtl/mul_share_arb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one sequential multiplier among N_REQ requesters; registered outputs.
// Latency: gnt 1 cycle after req in IDLE, rsp_valid 1 cycle after mul_done; waiters hold req until gnt.
module mul_share_arb #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [2*W-1:0]     rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               mul_start,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    input  logic [2*W-1:0]     mul_d_out,
    input  logic               mul_done
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PLAST = PW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [2*W-1:0]     rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;
    logic               mul_start_q, mul_start_d;
    logic [W-1:0]       mul_a_q, mul_a_d;
    logic [W-1:0]       mul_b_q, mul_b_d;

    logic               win_vld;
    logic [PW-1:0]      win_idx;

    // First requester at or after ptr, wrapping.
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = PW'(idx);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        timer_d     = timer_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mul_start_d = mul_start_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        case (state_q)
            IDLE: begin
                mul_start_d = 1'b0;
                if (win_vld) begin
                    mul_a_d     = req_a[win_idx*W +: W];
                    mul_b_d     = req_b[win_idx*W +: W];
                    owner_d     = win_idx;
                    gnt_d       = N_REQ'(1) << win_idx;
                    mul_start_d = 1'b1;
                    timer_d     = '0;
                    ptr_d       = (win_idx == PLAST) ? '0 : win_idx + PW'(1);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    rsp_data_d  = mul_d_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = N_REQ'(1) << owner_q;
                    mul_start_d = 1'b0;
                    state_d     = DRAIN;
                end else if (timer_q == TMAX) begin
                    // Hung multiplier: answer the owner with an error so others can proceed.
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = N_REQ'(1) << owner_q;
                    mul_start_d = 1'b0;
                    state_d     = DRAIN;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DRAIN: begin
                mul_start_d = 1'b0;
                if (!mul_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            timer_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            timer_q     <= timer_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule
